// File: rtl/d8m_pattern_source_if.sv
// rtl/d8m_pattern_source_if.sv - raw Bayer pixel stream bundle (D8M parallel-output shape)
interface d8m_pattern_source_if;
    logic [9:0]  oPIXEL_D;
    logic        oPIXEL_HS;
    logic        oPIXEL_VS;
    logic        oFRAME_DONE;
    logic [15:0] oFRAME_CNT;

    modport master (
        output oPIXEL_D,
        output oPIXEL_HS,
        output oPIXEL_VS,
        output oFRAME_DONE,
        output oFRAME_CNT
    );

    modport slave (
        input oPIXEL_D,
        input oPIXEL_HS,
        input oPIXEL_VS,
        input oFRAME_DONE,
        input oFRAME_CNT
    );
endinterface

// File: rtl/d8m_pattern_source.sv
// rtl/d8m_pattern_source.sv - synthetic D8M raw Bayer source with FVAL/LVAL timing
module d8m_pattern_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_PRE    = 2,
    parameter int V_ACTIVE = 480,
    parameter int V_POST   = 2,
    parameter int V_GAP    = 20
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    input  logic                        iEN,
    input  logic [1:0]                  iMODE,
    input  logic [9:0]                  iVALUE,
    d8m_pattern_source_if.master        pix
);
    localparam int          H_TOTAL     = H_ACTIVE + H_BLANK;
    localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
    localparam logic [15:0] H_ACT       = 16'(H_ACTIVE);
    localparam logic [15:0] BAR_LAST    = 16'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] PRE_LAST    = 16'(V_PRE - 1);
    localparam logic [15:0] ACTIVE_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] POST_LAST   = 16'(V_POST - 1);
    localparam logic [15:0] GAP_LAST    = 16'(V_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACTIVE, S_POST, S_GAP} state_t;

    state_t      state, state_nxt, frame_first;
    logic [15:0] hcnt, vcnt, bar_w_cnt, len_last, frame_cnt;
    logic [2:0]  bar;
    logic [1:0]  mode_q;
    logic [9:0]  value_q;
    logic        line_end, state_end, start;
    logic [9:0]  lvl_r, lvl_g, lvl_b, bar_sample, sample, pix_d;
    logic        hs_d, vs_d, done_d;

    assign frame_first = (V_PRE == 0) ? S_ACTIVE : S_PRE;
    assign line_end    = (hcnt == H_LAST);
    assign state_end   = line_end && (vcnt == len_last);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state           <= S_IDLE;
            hcnt            <= '0;
            vcnt            <= '0;
            bar_w_cnt       <= '0;
            bar             <= '0;
            mode_q          <= '0;
            value_q         <= '0;
            frame_cnt       <= '0;
            pix.oPIXEL_D    <= '0;
            pix.oPIXEL_HS   <= 1'b0;
            pix.oPIXEL_VS   <= 1'b0;
            pix.oFRAME_DONE <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                mode_q  <= iMODE;
                value_q <= iVALUE;
            end
            // Counters restart on every state change so vcnt is always the line index within the state
            if (state == S_IDLE || state_nxt != state) begin
                hcnt      <= '0;
                vcnt      <= '0;
                bar_w_cnt <= '0;
                bar       <= '0;
            end else if (line_end) begin
                hcnt      <= '0;
                vcnt      <= vcnt + 16'd1;
                bar_w_cnt <= '0;
                bar       <= '0;
            end else begin
                hcnt <= hcnt + 16'd1;
                if (bar_w_cnt == BAR_LAST) begin
                    bar_w_cnt <= '0;
                    bar       <= bar + 3'd1;
                end else begin
                    bar_w_cnt <= bar_w_cnt + 16'd1;
                end
            end
            pix.oPIXEL_D    <= pix_d;
            pix.oPIXEL_HS   <= hs_d;
            pix.oPIXEL_VS   <= vs_d;
            pix.oFRAME_DONE <= done_d;
            if (done_d) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign pix.oFRAME_CNT = frame_cnt;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        len_last  = GAP_LAST;
        case (state)
            S_IDLE: begin
                if (iEN) begin
                    start     = 1'b1;
                    state_nxt = frame_first;
                end
            end
            S_PRE: begin
                len_last = PRE_LAST;
                if (state_end) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                len_last = ACTIVE_LAST;
                if (state_end) state_nxt = (V_POST == 0) ? S_GAP : S_POST;
            end
            S_POST: begin
                len_last = POST_LAST;
                if (state_end) state_nxt = S_GAP;
            end
            S_GAP: begin
                len_last = GAP_LAST;
                if (state_end) begin
                    if (iEN) begin
                        start     = 1'b1;
                        state_nxt = frame_first;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        vs_d  = (state == S_PRE) || (state == S_ACTIVE) || (state == S_POST);
        hs_d  = (state == S_ACTIVE) && (hcnt < H_ACT);
        // GAP is only ever at line 0, pixel 0 on the cycle it is entered
        done_d = (state == S_GAP) && (hcnt == 16'd0) && (vcnt == 16'd0);
        lvl_r = bar[2] ? 10'd0 : 10'd1023;
        lvl_g = bar[1] ? 10'd0 : 10'd1023;
        lvl_b = bar[0] ? 10'd0 : 10'd1023;
        case ({vcnt[0], hcnt[0]})
            2'b00:   bar_sample = lvl_g;
            2'b01:   bar_sample = lvl_r;
            2'b10:   bar_sample = lvl_b;
            default: bar_sample = lvl_g;
        endcase
        case (mode_q)
            2'd0:    sample = bar_sample;
            2'd1:    sample = hcnt[9:0];
            2'd2:    sample = value_q;
            default: sample = (hcnt[3] ^ vcnt[3] ^ frame_cnt[0]) ? 10'd1023 : 10'd0;
        endcase
        pix_d = hs_d ? sample : 10'd0;
    end
endmodule

// File: tb/tb_d8m_pattern_source.sv
// tb/tb_d8m_pattern_source.sv - self-checking bench for d8m_pattern_source
module tb_d8m_pattern_source;
    localparam int HA = 16, HB = 4, VP = 1, VA = 4, VPO = 1, VG = 2;
    localparam int HT     = HA + HB;
    localparam int FV_LEN = (VP + VA + VPO) * HT;
    localparam int FR_LEN = FV_LEN + VG * HT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] value = 10'd0;

    d8m_pattern_source_if pif ();

    d8m_pattern_source #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_PRE(VP),
        .V_ACTIVE(VA), .V_POST(VPO), .V_GAP(VG)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iMODE(mode), .iVALUE(value),
        .pix(pif)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a 160-cycle timeline; outputs are a pure function of the offset into it
    function automatic logic [9:0] model_pixel(input int t, input logic [1:0] md,
                                               input logic [9:0] v, input logic [15:0] fc);
        int line, x, y, b, r, g, bl;
        line = t / HT;
        x    = t % HT;
        y    = line - VP;
        if (t >= FV_LEN || line < VP || line >= VP + VA || x >= HA) return 10'd0;
        case (md)
            2'd0: begin
                b  = x / (HA / 8);
                r  = (b & 4) != 0 ? 0 : 1023;
                g  = (b & 2) != 0 ? 0 : 1023;
                bl = (b & 1) != 0 ? 0 : 1023;
                if (y % 2 == 0) return 10'((x % 2 == 0) ? g : r);
                else            return 10'((x % 2 == 0) ? bl : g);
            end
            2'd1:    return 10'(x % 1024);
            2'd2:    return v;
            default: return ((((x / 8) % 2) ^ ((y / 8) % 2) ^ int'(fc[0])) != 0) ? 10'd1023 : 10'd0;
        endcase
    endfunction

    function automatic logic model_hs(input int t);
        int line;
        line = t / HT;
        return (t < FV_LEN) && (line >= VP) && (line < VP + VA) && ((t % HT) < HA);
    endfunction

    bit          m_valid = 0, m_run = 0;
    int          m_t = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [9:0]  m_val = 10'd0;
    logic [15:0] m_cnt = 16'd0;
    logic [9:0]  e_d = 10'd0;
    logic        e_hs = 1'b0, e_vs = 1'b0, e_done = 1'b0;
    logic [15:0] e_cnt = 16'd0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1; m_run = 0; m_cnt = 16'd0;
            e_d = 10'd0; e_hs = 1'b0; e_vs = 1'b0; e_done = 1'b0; e_cnt = 16'd0;
        end else begin
            if (m_run) begin
                e_vs   = (m_t < FV_LEN);
                e_hs   = model_hs(m_t);
                e_d    = model_pixel(m_t, m_mode, m_val, m_cnt);
                e_done = (m_t == FV_LEN);
                if (e_done) m_cnt = m_cnt + 16'd1;
            end else begin
                e_vs = 1'b0; e_hs = 1'b0; e_d = 10'd0; e_done = 1'b0;
            end
            e_cnt = m_cnt;
            if (!m_run) begin
                if (en) begin m_run = 1; m_t = 0; m_mode = mode; m_val = value; end
            end else if (m_t == FR_LEN - 1) begin
                if (en) begin m_t = 0; m_mode = mode; m_val = value; end
                else m_run = 0;
            end else begin
                m_t++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_pix_d", 16'(pif.oPIXEL_D), 16'(e_d));
            chk("model_hs", 16'(pif.oPIXEL_HS), 16'(e_hs));
            chk("model_vs", 16'(pif.oPIXEL_VS), 16'(e_vs));
            chk("model_done", 16'(pif.oFRAME_DONE), 16'(e_done));
            chk("model_cnt", pif.oFRAME_CNT, e_cnt);
        end
    end

    int rises = 0, since_rise = 0, run_len = 0, hi_len = 0, lo_len = 0;
    int first_hs = -1, hs_len = 0, hs_pulses = 0, hs_good = 0, done_seen = 0;
    bit pv = 0, ph = 0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            if (pif.oPIXEL_VS && !pv) begin
                lo_len = run_len; run_len = 1; rises++; since_rise = 0;
                first_hs = -1; hs_pulses = 0; hs_good = 0;
            end else if (!pif.oPIXEL_VS && pv) begin
                hi_len = run_len; run_len = 1; since_rise++;
            end else begin
                run_len++; since_rise++;
            end
            if (pif.oPIXEL_HS && !ph) begin
                if (first_hs < 0) first_hs = since_rise;
                hs_len = 1;
            end else if (pif.oPIXEL_HS) begin
                hs_len++;
            end else if (ph) begin
                hs_pulses++;
                if (hs_len == HA) hs_good++;
            end
            if (pif.oFRAME_DONE) done_seen++;
            pv = pif.oPIXEL_VS;
            ph = pif.oPIXEL_HS;
        end
    end

    task automatic wait_at(input int r, input int t);
        int n = 0;
        while (!(rises == r && since_rise == t) && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL wait_at_%0d_%0d actual=timeout required=reached", r, t);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_d"}, 16'(pif.oPIXEL_D), 16'd0);
        chk({name, "_hs"}, 16'(pif.oPIXEL_HS), 16'd0);
        chk({name, "_vs"}, 16'(pif.oPIXEL_VS), 16'd0);
        chk({name, "_done"}, 16'(pif.oFRAME_DONE), 16'd0);
    endtask

    int bars_y0 [6] = '{1023, 1023, 1023, 1023, 0, 1023};
    int bars_y1 [3] = '{1023, 1023, 0};

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset_cnt", pif.oFRAME_CNT, 16'd0);

        // Frame 0: ramp timing
        rst_n = 1'b1; en = 1'b1; mode = 2'd1;
        wait_at(1, 0);
        chk("start_vs", 16'(pif.oPIXEL_VS), 16'd1);
        mode = 2'd0;
        wait_at(1, 25);
        chk("ramp_x5", 16'(pif.oPIXEL_D), 16'd5);
        wait_at(1, 35);
        chk("ramp_x15", 16'(pif.oPIXEL_D), 16'd15);
        wait_at(1, 36);
        chk("blank_d", 16'(pif.oPIXEL_D), 16'd0);
        wait_at(1, 121);
        chk("first_hs_ofs", 16'(first_hs), 16'd20);
        chk("fval_high", 16'(hi_len), 16'd120);
        chk("lval_pulses", 16'(hs_pulses), 16'd4);
        chk("lval_len16", 16'(hs_good), 16'd4);
        chk("done_f0", 16'(done_seen), 16'd1);
        chk("cnt_f0", pif.oFRAME_CNT, 16'd1);

        // Frame 1: colour bars
        wait_at(2, 0);
        chk("fval_low", 16'(lo_len), 16'd40);
        for (int i = 0; i < 6; i++) begin
            wait_at(2, 20 + i);
            chk("bars_y0", 16'(pif.oPIXEL_D), 16'(bars_y0[i]));
        end
        for (int i = 0; i < 3; i++) begin
            wait_at(2, 40 + i);
            chk("bars_y1", 16'(pif.oPIXEL_D), 16'(bars_y1[i]));
        end
        mode = 2'd2; value = 10'h155;

        // Frame 2: solid, with a mid-frame change that must wait for frame 3
        wait_at(3, 20);
        chk("solid_first", 16'(pif.oPIXEL_D), 16'h155);
        mode = 2'd1; value = 10'h2AA;
        wait_at(3, 95);
        chk("solid_last", 16'(pif.oPIXEL_D), 16'h155);

        // Frame 3: ramp, run enable dropped mid-ACTIVE
        wait_at(4, 27);
        chk("ramp_next", 16'(pif.oPIXEL_D), 16'd7);
        wait_at(4, 50);
        en = 1'b0;
        wait_at(4, 200);
        chk("stop_fval_high", 16'(hi_len), 16'd120);
        chk("stop_done", 16'(done_seen), 16'd4);
        chk("stop_cnt", pif.oFRAME_CNT, 16'd4);
        chk("stop_rises", 16'(rises), 16'd4);
        chk_idle("stop_idle");

        // Frames 4,5: checker inverts per frame; reset lands mid-ACTIVE of frame 6
        mode = 2'd3; en = 1'b1;
        wait_at(5, 20);
        chk("checker_f4", 16'(pif.oPIXEL_D), 16'd0);
        wait_at(6, 20);
        chk("checker_f5", 16'(pif.oPIXEL_D), 16'd1023);
        wait_at(7, 50);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk_idle("midrst");
        chk("midrst_cnt", pif.oFRAME_CNT, 16'd0);
        rst_n = 1'b1; en = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("midrst_done", 16'(done_seen), 16'd6);
        chk_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
